adquisicion_temp: RTL and testbench
===================================

ADQUISICION_TEMP -- requirements
Module: adquisicion_temp

Interface
REQ-001 Parameter DIV_SCLK, default 4, clk cycles per SCLK half-period (min 2).
REQ-002 Parameter PERIODO_MUESTRA, default 200, idle clk cycles between conversions (min 2).
REQ-003 Parameter TEMP_MAX, default 1000, largest accepted temperature code (tenths of degree C).
REQ-004 clk  in  1  single system clock, rising-edge active.
REQ-005 arst_n  in  1  asynchronous active-low reset.
REQ-006 sensor_miso  in  1  serial data from the temperature sensor.
REQ-007 sensor_cs_n  out  1  sensor chip select, active low.
REQ-008 sensor_sclk  out  1  sensor serial clock, idle low.
REQ-009 temp_salida  out  10  last accepted temperature, unsigned tenths of degree C; drives monitoreo_top temp_entrada.
REQ-010 temp_valida  out  1  one-cycle pulse when temp_salida updates.
REQ-011 error_sensor  out  1  high after 3 consecutive rejected frames.

Function
REQ-012 The block SHALL implement FSM REPOSO -> SELECCION -> TRANSFERENCIA -> CIERRE -> REPOSO.
REQ-013 REPOSO: cs_n=1, sclk=0; counter SHALL run from 0 and move to SELECCION when count = PERIODO_MUESTRA-1.
REQ-014 SELECCION: cs_n=0, sclk=0 for DIV_SCLK cycles, then TRANSFERENCIA.
REQ-015 TRANSFERENCIA: cs_n=0; sclk SHALL toggle every DIV_SCLK cycles, starting with a rise, for exactly 16 rising edges, ending low after the 16th fall.
REQ-016 sensor_miso SHALL be sampled on the clk edge that drives sclk 0->1; bits shift in MSB first into a 16-bit register.
REQ-017 Frame format: [15:12] sync = 4'b1010, [11:2] temperature code, [1] reserved (ignored), [0] even parity so that [15:0] has an even count of ones.
REQ-018 CIERRE: one cycle, cs_n=1, sclk=0; frame SHALL be checked in this cycle.
REQ-019 Frame accepted iff sync matches, parity is even, and code <= TEMP_MAX (TEMP_MAX itself accepted).
REQ-020 Accepted: on the clk edge ending CIERRE, temp_salida <= code and temp_valida = 1 for exactly the following cycle; error counter cleared; error_sensor deasserts in that same cycle.
REQ-021 Rejected: temp_salida SHALL hold, no temp_valida pulse; 2-bit error counter increments, saturating at 3.
REQ-022 error_sensor SHALL equal (error counter == 3), registered; it stays high across further rejected frames.
REQ-023 Frame period (cs_n fall to cs_n fall) SHALL be PERIODO_MUESTRA + DIV_SCLK*33 + 1 cycles, fixed.
REQ-024 sensor_cs_n and sensor_sclk SHALL be registered outputs (glitch-free).

Reset
REQ-025 On arst_n low, all state SHALL clear immediately, independent of clk: FSM=REPOSO, counters=0, shift register=0.
REQ-026 Reset output values: sensor_cs_n=1, sensor_sclk=0, temp_salida=220 (22.0 C, normal band), temp_valida=0, error_sensor=0.
REQ-027 Reset asserted mid-transfer SHALL abort the frame with no temp_salida update; after release, the first cs_n fall occurs PERIODO_MUESTRA cycles later.

Verification
REQ-028 Reset release, sensor model returns code 220 valid frame -> one temp_valida pulse, temp_salida=220, error_sensor=0, exactly 16 sclk rises each of 8-clk period.
REQ-029 Frames with codes 150 then 265 -> temp_salida 150 then 265, one pulse each, spacing 333 clk cycles (defaults).
REQ-030 Frame code 1000 -> accepted; code 1001 -> rejected, temp_salida holds previous value, no pulse.
REQ-031 Single bad parity frame -> temp_salida held, error_sensor=0; 3 consecutive bad-sync frames -> error_sensor=1 in cycle after 3rd CIERRE; next good frame (code 200) -> error_sensor=0, temp_salida=200.
REQ-032 arst_n low during bit 8 of a frame carrying code 100 -> cs_n=1, sclk=0 immediately, temp_salida=220, no pulse; next full frame completes normally.

Source files
------------

// File: rtl/adquisicion_temp.sv
// Temperature sensor acquisition: periodic 16-bit SPI-like read,
// frame validation (sync, parity, range) and sensor error tracking.
module adquisicion_temp #(
    parameter int unsigned DIV_SCLK        = 4,
    parameter int unsigned PERIODO_MUESTRA = 200,
    parameter int unsigned TEMP_MAX        = 1000
) (
    input  logic       clk,
    input  logic       arst_n,
    input  logic       sensor_miso,
    output logic       sensor_cs_n,
    output logic       sensor_sclk,
    output logic [9:0] temp_salida,
    output logic       temp_valida,
    output logic       error_sensor
);

    localparam int unsigned CMAX =
        (PERIODO_MUESTRA > DIV_SCLK) ? PERIODO_MUESTRA : DIV_SCLK;
    localparam int unsigned CW = $clog2(CMAX + 1);

    localparam logic [CW-1:0] FIN_REPOSO = CW'(PERIODO_MUESTRA - 1);
    localparam logic [CW-1:0] FIN_MEDIO  = CW'(DIV_SCLK - 1);

    typedef enum logic [1:0] {
        REPOSO,
        SELECCION,
        TRANSFERENCIA,
        CIERRE
    } estado_t;

    estado_t       estado_q, estado_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [4:0]    medio_q, medio_d;
    logic [15:0]   trama_q;
    logic [1:0]    err_q, err_d;
    logic [9:0]    temp_d;
    logic          valida_d;
    logic          sclk_d;
    logic          cs_n_d;
    logic          muestrear;

    logic [9:0] codigo;
    logic       sync_ok;
    logic       paridad_ok;
    logic       rango_ok;
    logic       aceptar;

    assign codigo     = trama_q[11:2];
    assign sync_ok    = (trama_q[15:12] == 4'b1010);
    assign paridad_ok = ~^trama_q;
    assign rango_ok   = (32'(codigo) <= TEMP_MAX);
    assign aceptar    = sync_ok && paridad_ok && rango_ok;

    always_comb begin
        estado_d  = estado_q;
        cnt_d     = cnt_q + CW'(1);
        medio_d   = medio_q;
        sclk_d    = sensor_sclk;
        muestrear = 1'b0;
        temp_d    = temp_salida;
        valida_d  = 1'b0;
        err_d     = err_q;
        unique case (estado_q)
            REPOSO: begin
                sclk_d = 1'b0;
                if (cnt_q == FIN_REPOSO) begin
                    estado_d = SELECCION;
                    cnt_d    = '0;
                end
            end
            SELECCION: begin
                sclk_d = 1'b0;
                if (cnt_q == FIN_MEDIO) begin
                    estado_d  = TRANSFERENCIA;
                    cnt_d     = '0;
                    medio_d   = '0;
                    sclk_d    = 1'b1;
                    muestrear = 1'b1;
                end
            end
            TRANSFERENCIA: begin
                // 32 half-periods; odd ones are low, so the last ends low
                if (cnt_q == FIN_MEDIO) begin
                    cnt_d = '0;
                    if (medio_q == 5'd31) begin
                        estado_d = CIERRE;
                        sclk_d   = 1'b0;
                    end else begin
                        medio_d   = medio_q + 5'd1;
                        sclk_d    = ~sensor_sclk;
                        muestrear = ~sensor_sclk;
                    end
                end
            end
            CIERRE: begin
                estado_d = REPOSO;
                cnt_d    = '0;
                sclk_d   = 1'b0;
                if (aceptar) begin
                    temp_d   = codigo;
                    valida_d = 1'b1;
                    err_d    = 2'd0;
                end else if (err_q != 2'd3) begin
                    err_d = err_q + 2'd1;
                end
            end
            default: begin
                estado_d = REPOSO;
                cnt_d    = '0;
                sclk_d   = 1'b0;
            end
        endcase
        cs_n_d = (estado_d == REPOSO) || (estado_d == CIERRE);
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            estado_q     <= REPOSO;
            cnt_q        <= '0;
            medio_q      <= '0;
            trama_q      <= '0;
            err_q        <= 2'd0;
            sensor_cs_n  <= 1'b1;
            sensor_sclk  <= 1'b0;
            temp_salida  <= 10'd220;
            temp_valida  <= 1'b0;
            error_sensor <= 1'b0;
        end else begin
            estado_q     <= estado_d;
            cnt_q        <= cnt_d;
            medio_q      <= medio_d;
            err_q        <= err_d;
            sensor_cs_n  <= cs_n_d;
            sensor_sclk  <= sclk_d;
            temp_salida  <= temp_d;
            temp_valida  <= valida_d;
            error_sensor <= (err_d == 2'd3);
            if (muestrear) begin
                trama_q <= {trama_q[14:0], sensor_miso};
            end
        end
    end

endmodule

// File: tb/tb_adquisicion_temp.sv
// Directed bench for adquisicion_temp with a behavioural
// sensor that shifts a 16-bit frame out MSB first.
module tb_adquisicion_temp;

    localparam int DIV = 4;
    localparam int PER = 200;

    logic       clk;
    logic       arst_n;
    logic       sensor_miso;
    logic       sensor_cs_n;
    logic       sensor_sclk;
    logic [9:0] temp_salida;
    logic       temp_valida;
    logic       error_sensor;

    adquisicion_temp #(
        .DIV_SCLK(DIV),
        .PERIODO_MUESTRA(PER),
        .TEMP_MAX(1000)
    ) dut (
        .clk(clk),
        .arst_n(arst_n),
        .sensor_miso(sensor_miso),
        .sensor_cs_n(sensor_cs_n),
        .sensor_sclk(sensor_sclk),
        .temp_salida(temp_salida),
        .temp_valida(temp_valida),
        .error_sensor(error_sensor)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int pulses = 0;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (temp_valida === 1'b1) pulses <= pulses + 1;

    // Sensor model: bit 15 presented at cs_n fall, next bit on each sclk fall
    logic [15:0] next_frame = '0;
    logic [15:0] cur_frame = '0;
    int idx = -1;
    always @(negedge sensor_cs_n) begin
        cur_frame = next_frame;
        idx = 15;
    end
    always @(negedge sensor_sclk) if (idx > 0) idx = idx - 1;
    assign sensor_miso = (idx >= 0 && idx < 16) ? cur_frame[idx] : 1'b0;

    int g_wait, g_rises, g_badper, g_fall, g_pulses;
    logic g_val_now, g_val_after, g_err;
    logic [9:0] g_temp;

    function automatic logic [15:0] mk_frame(input logic [3:0] s,
                                              input logic [9:0] c,
                                              input logic bad);
        logic [15:0] f;
        f = {s, c, 2'b00};
        f[0] = (^f[15:1]) ^ bad;
        return f;
    endfunction

    task automatic do_frame(input logic [15:0] f);
        int n;
        int last_rise;
        int p0;
        logic prev;
        next_frame = f;
        g_rises = 0;
        g_badper = 0;
        last_rise = 0;
        p0 = pulses;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (sensor_cs_n && n < 3000);
        g_wait = n;
        if (sensor_cs_n) begin
            checks++; errors++;
            $display("FAIL cs_fall_timeout: cs_n=%b after %0d cycles, required 0",
                     sensor_cs_n, n);
            return;
        end
        g_fall = cyc;
        prev = sensor_sclk;
        n = 0;
        while (!sensor_cs_n && n < 3000) begin
            @(posedge clk); #1;
            n++;
            if (sensor_sclk && !prev) begin
                g_rises++;
                if (g_rises > 1 && cyc - last_rise != 2 * DIV) g_badper++;
                last_rise = cyc;
            end
            prev = sensor_sclk;
        end
        if (!sensor_cs_n) begin
            checks++; errors++;
            $display("FAIL cs_rise_timeout: cs_n=%b, required 1", sensor_cs_n);
            return;
        end
        @(posedge clk); #1;
        g_val_now = temp_valida;
        g_err = error_sensor;
        g_temp = temp_salida;
        @(posedge clk); #1;
        g_val_after = temp_valida;
        g_pulses = pulses - p0;
    endtask

    task automatic test_reset;
        arst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (sensor_cs_n !== 1'b1) begin
            errors++; $display("FAIL rst_cs_n: got %b want 1", sensor_cs_n);
        end
        checks++;
        if (sensor_sclk !== 1'b0) begin
            errors++; $display("FAIL rst_sclk: got %b want 0", sensor_sclk);
        end
        checks++;
        if (temp_salida !== 10'd220) begin
            errors++; $display("FAIL rst_temp: got %0d want 220", temp_salida);
        end
        checks++;
        if (temp_valida !== 1'b0) begin
            errors++; $display("FAIL rst_valida: got %b want 0", temp_valida);
        end
        checks++;
        if (error_sensor !== 1'b0) begin
            errors++; $display("FAIL rst_error: got %b want 0", error_sensor);
        end
    endtask

    task automatic test_first_frame;
        @(negedge clk);
        arst_n = 1'b1;
        do_frame(mk_frame(4'b1010, 10'd220, 1'b0));
        checks++;
        if (g_wait !== PER) begin
            errors++; $display("FAIL first_cs_fall: got %0d want %0d", g_wait, PER);
        end
        checks++;
        if (g_rises !== 16) begin
            errors++; $display("FAIL sclk_rises: got %0d want 16", g_rises);
        end
        checks++;
        if (g_badper !== 0) begin
            errors++; $display("FAIL sclk_period: got %0d bad periods want 0", g_badper);
        end
        checks++;
        if (g_val_now !== 1'b1 || g_val_after !== 1'b0 || g_pulses !== 1) begin
            errors++;
            $display("FAIL pulse_220: got now=%b after=%b n=%0d want 1 0 1",
                     g_val_now, g_val_after, g_pulses);
        end
        checks++;
        if (g_temp !== 10'd220 || g_err !== 1'b0) begin
            errors++; $display("FAIL temp_220: got %0d err=%b want 220 err=0", g_temp, g_err);
        end
    endtask

    task automatic test_back_to_back;
        int f1;
        do_frame(mk_frame(4'b1010, 10'd150, 1'b0));
        f1 = g_fall;
        checks++;
        if (g_temp !== 10'd150 || g_pulses !== 1) begin
            errors++; $display("FAIL temp_150: got %0d n=%0d want 150 1", g_temp, g_pulses);
        end
        do_frame(mk_frame(4'b1010, 10'd265, 1'b0));
        checks++;
        if (g_temp !== 10'd265 || g_pulses !== 1) begin
            errors++; $display("FAIL temp_265: got %0d n=%0d want 265 1", g_temp, g_pulses);
        end
        checks++;
        if (g_fall - f1 !== PER + 33 * DIV + 1) begin
            errors++;
            $display("FAIL frame_period: got %0d want %0d", g_fall - f1, PER + 33 * DIV + 1);
        end
    endtask

    task automatic test_limits;
        do_frame(mk_frame(4'b1010, 10'd1000, 1'b0));
        checks++;
        if (g_temp !== 10'd1000 || g_pulses !== 1) begin
            errors++; $display("FAIL temp_max: got %0d n=%0d want 1000 1", g_temp, g_pulses);
        end
        do_frame(mk_frame(4'b1010, 10'd1001, 1'b0));
        checks++;
        if (g_temp !== 10'd1000 || g_pulses !== 0 || g_err !== 1'b0) begin
            errors++;
            $display("FAIL temp_over: got %0d n=%0d err=%b want 1000 0 0",
                     g_temp, g_pulses, g_err);
        end
        do_frame(mk_frame(4'b1010, 10'd500, 1'b0));
        checks++;
        if (g_temp !== 10'd500 || g_pulses !== 1) begin
            errors++; $display("FAIL temp_500: got %0d n=%0d want 500 1", g_temp, g_pulses);
        end
    endtask

    task automatic test_errors;
        logic [1:0] want_err [4];
        want_err = '{1'b0, 1'b0, 1'b1, 1'b1};
        do_frame(mk_frame(4'b1010, 10'd300, 1'b1));
        checks++;
        if (g_temp !== 10'd500 || g_pulses !== 0 || g_err !== 1'b0) begin
            errors++;
            $display("FAIL bad_parity: got %0d n=%0d err=%b want 500 0 0",
                     g_temp, g_pulses, g_err);
        end
        do_frame(mk_frame(4'b1010, 10'd420, 1'b0));
        checks++;
        if (g_temp !== 10'd420 || g_err !== 1'b0) begin
            errors++; $display("FAIL temp_420: got %0d err=%b want 420 0", g_temp, g_err);
        end
        for (int i = 0; i < 4; i++) begin
            do_frame(mk_frame(4'b0101, 10'd300, 1'b0));
            checks++;
            if (g_err !== want_err[i][0] || g_temp !== 10'd420 || g_pulses !== 0) begin
                errors++;
                $display("FAIL bad_sync_%0d: got err=%b temp=%0d n=%0d want err=%b 420 0",
                         i, g_err, g_temp, g_pulses, want_err[i][0]);
            end
        end
        do_frame(mk_frame(4'b1010, 10'd200, 1'b0));
        checks++;
        if (g_err !== 1'b0 || g_temp !== 10'd200 || g_pulses !== 1) begin
            errors++;
            $display("FAIL recover: got err=%b temp=%0d n=%0d want 0 200 1",
                     g_err, g_temp, g_pulses);
        end
    endtask

    task automatic test_reset_mid;
        int n;
        int r;
        int p0;
        logic prev;
        next_frame = mk_frame(4'b1010, 10'd100, 1'b0);
        p0 = pulses;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (sensor_cs_n && n < 3000);
        r = 0;
        prev = sensor_sclk;
        while (r < 8 && n < 6000) begin
            @(posedge clk); #1;
            n++;
            if (sensor_sclk && !prev) r++;
            prev = sensor_sclk;
        end
        checks++;
        if (r !== 8) begin
            errors++; $display("FAIL mid_reach_bit8: got %0d rises want 8", r);
        end
        #1 arst_n = 1'b0;
        #1;
        checks++;
        if (sensor_cs_n !== 1'b1 || sensor_sclk !== 1'b0) begin
            errors++;
            $display("FAIL mid_abort: got cs_n=%b sclk=%b want 1 0", sensor_cs_n, sensor_sclk);
        end
        checks++;
        if (temp_salida !== 10'd220 || temp_valida !== 1'b0) begin
            errors++;
            $display("FAIL mid_temp: got %0d v=%b want 220 0", temp_salida, temp_valida);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        arst_n = 1'b1;
        checks++;
        if (pulses !== p0) begin
            errors++; $display("FAIL mid_no_pulse: got %0d pulses want 0", pulses - p0);
        end
        do_frame(mk_frame(4'b1010, 10'd100, 1'b0));
        checks++;
        if (g_wait !== PER) begin
            errors++; $display("FAIL mid_restart: got %0d want %0d", g_wait, PER);
        end
        checks++;
        if (g_temp !== 10'd100 || g_pulses !== 1 || g_rises !== 16) begin
            errors++;
            $display("FAIL mid_next: got %0d n=%0d rises=%0d want 100 1 16",
                     g_temp, g_pulses, g_rises);
        end
    endtask

    initial begin
        arst_n = 1'b0;
        test_reset();
        test_first_frame();
        test_back_to_back();
        test_limits();
        test_errors();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
